// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first over WIDTH cycles.
// Define SERIAL_ADDER_SUB_EN to build subtract mode; otherwise `sub` is ignored and the unit is add-only.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic             b_bit_d;
  logic             s_bit_d;
  logic             carry_d;
  logic             carry_init_d;

`ifdef SERIAL_ADDER_SUB_EN
  logic             sub_q;

  always_comb begin
    b_bit_d      = b_q[0] ^ sub_q;
    carry_init_d = sub ? 1'b1 : cin;
  end
`else
  logic             unused_sub;

  assign unused_sub = sub;

  always_comb begin
    b_bit_d      = b_q[0];
    carry_init_d = cin;
  end
`endif

  always_comb begin
    s_bit_d = a_q[0] ^ b_bit_d ^ carry_q;
    carry_d = (a_q[0] & b_bit_d) | (carry_q & (a_q[0] ^ b_bit_d));
  end

  // Operand and partial-sum registers are not reset; they are reloaded on every accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= sub;
`endif
            carry_q <= carry_init_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sh_q    <= {s_bit_d, sh_q[WIDTH-1:1]};
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          // On the last bit carry_q is the carry into the MSB.
          if (cnt_q == CW'(WIDTH - 1)) begin
            sum_q   <= {s_bit_d, sh_q[WIDTH-1:1]};
            cout_q  <= carry_d;
            ovf_q   <= carry_q ^ carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three instances (WIDTH 8, 2, 64) checked against an arithmetic model.
module tb_serial_adder;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0][63:0] a_s, b_s;
  logic [2:0]       start_s, cin_s, sub_s, rstn_s;
  logic [7:0]       sum0;
  logic [1:0]       sum1;
  logic [63:0]      sum2;
  logic [2:0]       cout_w, ovf_w, busy_w, done_w;
  logic [63:0]      sum_w [3];

  always_comb begin
    sum_w[0] = 64'(sum0);
    sum_w[1] = 64'(sum1);
    sum_w[2] = sum2;
  end

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rstn_s[0]), .start(start_s[0]), .a(a_s[0][7:0]), .b(b_s[0][7:0]),
    .cin(cin_s[0]), .sub(sub_s[0]), .sum(sum0), .cout(cout_w[0]), .ovf(ovf_w[0]),
    .busy(busy_w[0]), .done(done_w[0]));

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rstn_s[1]), .start(start_s[1]), .a(a_s[1][1:0]), .b(b_s[1][1:0]),
    .cin(cin_s[1]), .sub(sub_s[1]), .sum(sum1), .cout(cout_w[1]), .ovf(ovf_w[1]),
    .busy(busy_w[1]), .done(done_w[1]));

  serial_adder #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst_n(rstn_s[2]), .start(start_s[2]), .a(a_s[2]), .b(b_s[2]),
    .cin(cin_s[2]), .sub(sub_s[2]), .sum(sum2), .cout(cout_w[2]), .ovf(ovf_w[2]),
    .busy(busy_w[2]), .done(done_w[2]));

  int   errors = 0;
  int   checks = 0;
  exp_t sbq [3][$];
  exp_t last [3];

  function automatic int wd(int i);
    return (i == 0) ? 8 : ((i == 1) ? 2 : 64);
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // Reference: plain integer arithmetic; overflow from the operand/result sign rule.
  function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b, logic c, logic s);
    logic [64:0] mask, aa, bb, r;
    logic        cc;
    exp_t        e;
    mask = (65'd1 << w) - 65'd1;
    aa   = {1'b0, a} & mask;
    bb   = {1'b0, b} & mask;
    cc   = c;
    if (SUB_EN && s) begin
      bb = ~bb & mask;
      cc = 1'b1;
    end
    r      = aa + bb + {64'd0, cc};
    e.sum  = r[63:0] & mask[63:0];
    e.cout = r[w];
    e.ovf  = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
    e.cyc  = 0;
    return e;
  endfunction

  function automatic void chk(string nm, int i, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h expected %0h", i, nm, act, expv);
    end
  endfunction

  task automatic check_zero(int i);
    chk("reset_sum", i, sum_w[i], 64'd0);
    chk("reset_cout", i, 64'(cout_w[i]), 64'd0);
    chk("reset_ovf", i, 64'(ovf_w[i]), 64'd0);
    chk("reset_busy", i, 64'(busy_w[i]), 64'd0);
    chk("reset_done", i, 64'(done_w[i]), 64'd0);
  endtask

  // Called just after a falling edge; waits until the DUT can accept, then presents one request.
  task automatic issue(int i, logic [63:0] a, logic [63:0] b, logic c, logic s, bit hold, bit junk);
    exp_t e;
    int   n = 0;
    while (busy_w[i] && n < 200) begin
      if (junk) begin
        start_s[i] = 1'($urandom);
        a_s[i]     = r64();
        b_s[i]     = r64();
        cin_s[i]   = 1'($urandom);
        sub_s[i]   = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      errors++;
      checks++;
      $display("FAIL dut%0d accept_timeout: busy stuck at %0d", i, busy_w[i]);
    end
    a_s[i]     = a;
    b_s[i]     = b;
    cin_s[i]   = c;
    sub_s[i]   = s;
    start_s[i] = 1'b1;
    e          = model(wd(i), a, b, c, s);
    e.cyc      = cyc;
    sbq[i].push_back(e);
    @(negedge clk);
    if (!hold) start_s[i] = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rstn_s[i] && done_w[i]) begin
        if (sbq[i].size() == 0) begin
          errors++;
          checks++;
          $display("FAIL dut%0d unexpected_done: got done=1 expected none pending", i);
        end else begin
          exp_t e;
          e = sbq[i].pop_front();
          chk("sum", i, sum_w[i], e.sum);
          chk("cout", i, 64'(cout_w[i]), 64'(e.cout));
          chk("ovf", i, 64'(ovf_w[i]), 64'(e.ovf));
          chk("latency", i, 64'(cyc - e.cyc), 64'(wd(i) + 1));
          last[i] = e;
        end
      end else if (rstn_s[i]) begin
        chk("hold_sum", i, sum_w[i], last[i].sum);
        chk("hold_flags", i, {62'd0, cout_w[i], ovf_w[i]}, {62'd0, last[i].cout, last[i].ovf});
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      last[i].sum  = '0;
      last[i].cout = 1'b0;
      last[i].ovf  = 1'b0;
      last[i].cyc  = 0;
    end
    rstn_s  = '0;
    start_s = '0;
    cin_s   = '0;
    sub_s   = '0;
    a_s     = '0;
    b_s     = '0;
    repeat (3) @(negedge clk);
    rstn_s = '1;
    for (int i = 0; i < 3; i++) check_zero(i);

    issue(0, 64'h5A, 64'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(0, 64'hFF, 64'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(0, 64'h7F, 64'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(0, 64'h10, 64'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(0, 64'h80, 64'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(1, 64'h3, 64'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, 1'b0);

    // start held high across back-to-back operations
    for (int n = 0; n < 6; n++)
      issue(0, r64(), r64(), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
    issue(0, r64(), r64(), 1'($urandom), 1'($urandom), 1'b0, 1'b0);

    // stray start pulses and operand noise during SHIFT
    for (int n = 0; n < 6; n++)
      issue(0, r64(), r64(), 1'($urandom), 1'($urandom), 1'b0, 1'b1);

    // reset mid-operation at bit 4
    issue(0, 64'hA5, 64'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rstn_s[0] = 1'b0;
    @(posedge clk);
    #1;
    sbq[0].delete();
    last[0].sum  = '0;
    last[0].cout = 1'b0;
    last[0].ovf  = 1'b0;
    @(negedge clk);
    rstn_s[0] = 1'b1;
    check_zero(0);
    repeat (12) @(negedge clk);
    issue(0, 64'h5A, 64'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

    fork
      for (int n = 0; n < 1000; n++)
        issue(1, r64(), r64(), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      for (int n = 0; n < 1000; n++)
        issue(2, r64(), r64(), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      for (int n = 0; n < 300; n++)
        issue(0, r64(), r64(), 1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
    join

    for (int n = 0; n < 300; n++) begin
      if (sbq[0].size() == 0 && sbq[1].size() == 0 && sbq[2].size() == 0) break;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sbq[i].size() != 0) begin
        errors++;
        $display("FAIL dut%0d drain: got %0d results outstanding expected 0", i, sbq[i].size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
